// File: rtl/hex_sub_arb_if.sv
// Bus interface for hex_sub_arb: two requester channels plus the response
// channel and status outputs. The slave modport is the DUT side.
interface hex_sub_arb_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req1_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req0_ready;
    logic             req1_ready;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_borrow;
    logic             resp_id;
    logic             busy;
    logic [15:0]      op_count;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  resp_ready,
        output req0_ready, req1_ready, resp_valid, resp_data, resp_borrow,
        output resp_id, busy, op_count
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output resp_ready,
        input  req0_ready, req1_ready, resp_valid, resp_data, resp_borrow,
        input  resp_id, busy, op_count
    );
endinterface

// File: rtl/hex_sub_arb.sv
// hex_sub_arb: two-requester round-robin arbiter in front of a single
// subtractor. IDLE grants and accepts, EXEC computes a - b, RESP holds the
// result until the consumer takes it.
// Optional macro HEX_SUB_SAT_EN: clamp underflowing results to zero
// (borrow still reported).
module hex_sub_arb #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    hex_sub_arb_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic             r_rr;
    logic             r_id;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_data;
    logic             r_borrow;
    logic [15:0]      r_count;

    logic             w_grant;
    logic             w_ready0;
    logic             w_ready1;
    logic             w_accept;
    logic             w_resp_done;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;
    logic [WIDTH-1:0] w_result;

    // Grant selection: a lone requester wins, contention resolved by rr.
    always_comb begin
        w_grant = r_rr;
        if (bus.req0_valid && !bus.req1_valid) begin
            w_grant = 1'b0;
        end else if (!bus.req0_valid && bus.req1_valid) begin
            w_grant = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and handshake strobes.
    always_comb begin
        w_next      = r_state;
        w_ready0    = 1'b0;
        w_ready1    = 1'b0;
        w_accept    = 1'b0;
        w_resp_done = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready0 = bus.req0_valid && (w_grant == 1'b0);
                w_ready1 = bus.req1_valid && (w_grant == 1'b1);
                w_accept = w_ready0 || w_ready1;
                if (w_accept) begin
                    w_next = EXEC;
                end
            end
            EXEC: begin
                w_next = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_resp_done = 1'b1;
                    w_next      = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Subtractor on the latched operands.
    always_comb begin
        w_diff   = r_a - r_b;
        w_borrow = (r_a < r_b);
`ifdef HEX_SUB_SAT_EN
        w_result = w_borrow ? '0 : w_diff;
`else
        w_result = w_diff;
`endif
    end

    // Operand capture, rr update on accept, result register in EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr     <= 1'b0;
            r_id     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_data   <= '0;
            r_borrow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_id <= w_grant;
                r_rr <= ~w_grant;
                r_a  <= w_grant ? bus.req1_a : bus.req0_a;
                r_b  <= w_grant ? bus.req1_b : bus.req0_b;
            end
            if (r_state == EXEC) begin
                r_data   <= w_result;
                r_borrow <= w_borrow;
            end
        end
    end

    // Completed-response counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_resp_done) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign bus.req0_ready  = w_ready0;
    assign bus.req1_ready  = w_ready1;
    assign bus.resp_valid  = (r_state == RESP);
    assign bus.resp_data   = r_data;
    assign bus.resp_borrow = r_borrow;
    assign bus.resp_id     = r_id;
    assign bus.busy        = (r_state != IDLE);
    assign bus.op_count    = r_count;
endmodule

// File: tb/tb_hex_sub_arb.sv
// Testbench for hex_sub_arb: directed vectors, expected responses queued by
// the stimulus and checked by an independent monitor on response handshakes.
module tb_hex_sub_arb;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    typedef struct packed {
        logic [7:0] data;
        logic       borrow;
        logic       id;
    } exp_t;

    exp_t exp_q[$];

    hex_sub_arb_if #(.WIDTH(8)) bus ();

    hex_sub_arb #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef HEX_SUB_SAT_EN
    localparam logic [7:0] UNDER_10_20 = 8'h00;
    localparam logic [7:0] UNDER_04_09 = 8'h00;
`else
    localparam logic [7:0] UNDER_10_20 = 8'hF0;
    localparam logic [7:0] UNDER_04_09 = 8'hFB;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every completed response against the queue head.
    always @(negedge clk) begin
        if (!rst && bus.resp_valid && bus.resp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got id=%0d data=0x%0h with empty queue",
                         bus.resp_id, bus.resp_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_data", 32'(bus.resp_data), 32'(e.data));
                chk("resp_borrow", 32'(bus.resp_borrow), 32'(e.borrow));
                chk("resp_id", 32'(bus.resp_id), 32'(e.id));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_single(input logic sel, input logic [7:0] a, input logic [7:0] b,
                              input exp_t e, input logic [15:0] cnt_after);
        if (sel) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
        end
        #1;
        chk("ready_sel", 32'(sel ? bus.req1_ready : bus.req0_ready), 32'd1);
        chk("ready_other", 32'(sel ? bus.req0_ready : bus.req1_ready), 32'd0);
        exp_q.push_back(e);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("exec_busy", 32'(bus.busy), 32'd1);
        chk("exec_no_valid", 32'(bus.resp_valid), 32'd0);
        tick();
        chk("resp_valid_latency", 32'(bus.resp_valid), 32'd1);
        tick();
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("op_count", 32'(bus.op_count), 32'(cnt_after));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.resp_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", 32'(bus.resp_data), 32'd0);
        chk("rst_resp_borrow", 32'(bus.resp_borrow), 32'd0);
        chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_op_count", 32'(bus.op_count), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Plain subtraction, underflow, and equal operands.
        run_single(1'b0, 8'h3C, 8'h15, '{data: 8'h27, borrow: 1'b0, id: 1'b0}, 16'd1);
        run_single(1'b1, 8'h10, 8'h20, '{data: UNDER_10_20, borrow: 1'b1, id: 1'b1}, 16'd2);
        run_single(1'b0, 8'h55, 8'h55, '{data: 8'h00, borrow: 1'b0, id: 1'b0}, 16'd3);

        // Backpressure, with requester inputs churning while busy.
        bus.resp_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 8'h80; bus.req0_b = 8'h01;
        exp_q.push_back('{data: 8'h7F, borrow: 1'b0, id: 1'b0});
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 8'hAA; bus.req1_b = 8'h11;
        tick();
        for (int unsigned i = 0; i < 5; i++) begin
            chk("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("bp_data_stable", 32'(bus.resp_data), 32'h7F);
            chk("bp_ready0", 32'(bus.req0_ready), 32'd0);
            chk("bp_ready1", 32'(bus.req1_ready), 32'd0);
            chk("bp_busy", 32'(bus.busy), 32'd1);
            tick();
        end
        bus.resp_ready = 1'b1;
        tick();
        chk("bp_op_count", 32'(bus.op_count), 32'd4);
        chk("bp_idle_grant1", 32'(bus.req1_ready), 32'd1);
        bus.req1_valid = 1'b0;
        #1;
        chk("drop_valid_ready1", 32'(bus.req1_ready), 32'd0);

        // Reset during EXEC: rr is 1 here, accept req0 to keep it at 1.
        bus.req0_valid = 1'b1; bus.req0_a = 8'h01; bus.req0_b = 8'h01;
        tick();
        bus.req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rexec_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rexec_busy", 32'(bus.busy), 32'd0);
        chk("rexec_op_count", 32'(bus.op_count), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rexec_still_idle", 32'(bus.resp_valid), 32'd0);

        // Contention: both valid continuously, alternating grants from req0.
        bus.req0_valid = 1'b1; bus.req0_a = 8'h09; bus.req0_b = 8'h04;
        bus.req1_valid = 1'b1; bus.req1_a = 8'h04; bus.req1_b = 8'h09;
        for (int unsigned k = 0; k < 4; k++) begin
            logic g;
            g = k[0];
            #1;
            chk("cont_ready_granted", 32'(g ? bus.req1_ready : bus.req0_ready), 32'd1);
            chk("cont_ready_other", 32'(g ? bus.req0_ready : bus.req1_ready), 32'd0);
            if (g) exp_q.push_back('{data: UNDER_04_09, borrow: 1'b1, id: 1'b1});
            else   exp_q.push_back('{data: 8'h05, borrow: 1'b0, id: 1'b0});
            tick();
            chk("cont_exec_readys", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
            tick();
            chk("cont_resp_readys", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
            tick();
        end
        chk("cont_op_count", 32'(bus.op_count), 32'd4);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hex_sub_arb.md
HEX_SUB_ARB -- requirements
Module: hex_sub_arb

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: req0_valid, req1_valid  input  1 each  requester has an operand pair pending.
REQ-005 SHALL have ports: req0_a, req0_b, req1_a, req1_b  input  WIDTH each  minuend (a) and subtrahend (b) per requester.
REQ-006 SHALL have ports: req0_ready, req1_ready  output  1 each  request accepted on the edge where valid and ready are both high.
REQ-007 SHALL have port: resp_valid  output  1  result available.
REQ-008 SHALL have port: resp_ready  input  1  consumer accepts the result.
REQ-009 SHALL have port: resp_data  output  WIDTH  result of a minus b.
REQ-010 SHALL have port: resp_borrow  output  1  high when a < b (unsigned).
REQ-011 SHALL have port: resp_id  output  1  index of the requester that owns the result.
REQ-012 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port: op_count  output  16  count of completed response handshakes; wraps from 0xFFFF to 0.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE, EXEC, RESP.
REQ-015 In IDLE, grant SHALL be combinational:
  - Only one valid requester: that requester is granted.
  - Both valid: the requester selected by the round-robin pointer rr is granted.
REQ-016 req<g>_ready SHALL be high only in IDLE and only for the granted requester; the other ready and both readys outside IDLE SHALL be low.
REQ-017 On an accept edge, the FSM SHALL:
  - latch a, b and the grant index;
  - set rr to the other requester;
  - go IDLE->EXEC.
REQ-018 EXEC SHALL last exactly one cycle, register resp_data = (a - b) mod 2^WIDTH and resp_borrow = (a < b), then go EXEC->RESP.
REQ-019 In RESP, resp_valid SHALL be high.
REQ-020 In RESP, resp_data, resp_borrow and resp_id SHALL hold stable until the edge where resp_ready is high; on that edge the FSM SHALL go RESP->IDLE and op_count SHALL increment by 1.
REQ-021 Latency: a request accepted at edge N SHALL have resp_valid high in the cycle after edge N+1.
REQ-022 Throughput: the block SHALL accept at most one request per 3 cycles; there SHALL be no accept in the cycle that completes the response.
REQ-023 a == b SHALL give resp_data 0 and resp_borrow 0.
REQ-024 Requester inputs changing while the FSM is not in IDLE SHALL NOT affect the operation in flight.
REQ-025 rr SHALL change only on an accept edge.
REQ-026 A requester dropping valid in IDLE before acceptance SHALL be allowed; grant then re-evaluates combinationally.

Reset
REQ-027 rst high SHALL immediately set:
  - FSM = IDLE, rr = 0;
  - resp_valid 0, resp_data 0, resp_borrow 0, resp_id 0;
  - busy 0, op_count 0.
REQ-028 Reset asserted during EXEC or RESP SHALL discard the operation in flight with no response issued and no op_count increment.
REQ-029 After reset deasserts, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-030 With macro HEX_SUB_SAT_EN defined, a < b SHALL produce resp_data = 0, with resp_borrow still 1.
REQ-031 Without HEX_SUB_SAT_EN, a < b SHALL produce the wrapped two's-complement difference.

Verification
REQ-032 Single request: req0 a=0x3C, b=0x15 -> resp_data 0x27, borrow 0, id 0, resp_valid in the 2nd cycle after the accept edge.
REQ-033 Underflow: req1 a=0x10, b=0x20 -> borrow 1, id 1, resp_data 0xF0 without the macro and 0x00 with HEX_SUB_SAT_EN.
REQ-034 Contention: both valid continuously from reset, resp_ready=1 -> ids in order 0,1,0,1; one accept every 3 cycles; op_count 4 after four responses.
REQ-035 Backpressure: resp_ready held 0 for 5 cycles in RESP -> resp_data stable, both readys 0, busy 1; resp_ready=1 -> back to IDLE, op_count +1.
REQ-036 Reset in EXEC: rst pulse one cycle after accept -> no resp_valid, op_count 0, rr 0, next accept goes to req0 when both requesters are valid.
